// File: rtl/seq_mult_32.sv
// Radix-2 shift-add 32x32 -> 64-bit multiplier, signed or unsigned, one partial product per clock.
// Signed operands are reduced to magnitudes on entry and the product is negated in the FIX state.
module seq_mult_32 #(
  parameter int N = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         SIGNED,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         READY,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] HI,
  output logic [N-1:0] LO
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // N-bit two's-complement negation
  function automatic logic [N-1:0] neg_n(input logic [N-1:0] x);
    return ~x + {{(N-1){1'b0}}, 1'b1};
  endfunction

  // 2N-bit two's-complement negation
  function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] x);
    return ~x + {{(2*N-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand; -2^(N-1) maps to 2^(N-1), which still fits unsigned
  function automatic logic [N-1:0] mag_n(input logic [N-1:0] x, input logic sgn);
    if (sgn && x[N-1]) begin
      return neg_n(x);
    end else begin
      return x;
    end
  endfunction

  state_t          state_r;
  state_t          state_next_s;
  logic [N-1:0]    mcand_r;
  logic [N-1:0]    mplier_r;
  logic [2*N-1:0]  acc_r;
  logic            neg_r;
  logic [CW-1:0]   cnt_r;
  logic [N-1:0]    hi_r;
  logic [N-1:0]    lo_r;

  logic [N-1:0]    addend_s;
  logic [N:0]      sum_s;
  logic [2*N-1:0]  acc_step_s;
  logic            last_step_s;
  logic            accept_s;

  // One shift-add step: carry-keeping upper add, then shift {carry,acc} right by one
  always_comb begin
    addend_s    = {N{1'b0}};
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {N{1'b0}};
    end
    sum_s       = {1'b0, acc_r[2*N-1:N]} + {1'b0, addend_s};
    acc_step_s  = {sum_s, acc_r[N-1:1]};
    last_step_s = (cnt_r == CW'(N - 1));
    accept_s    = START && ((state_r == S_IDLE) || (state_r == S_DONE));
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (START) begin
          state_next_s = S_RUN;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_step_s) begin
          state_next_s = S_FIX;
        end else begin
          state_next_s = S_RUN;
        end
      end
      S_FIX: begin
        state_next_s = S_DONE;
      end
      S_DONE: begin
        if (START) begin
          state_next_s = S_RUN;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    READY = 1'b0;
    BUSY  = 1'b0;
    DONE  = 1'b0;
    case (state_r)
      S_IDLE: begin
        READY = 1'b1;
      end
      S_RUN, S_FIX: begin
        BUSY = 1'b1;
      end
      S_DONE: begin
        READY = 1'b1;
        DONE  = 1'b1;
      end
      default: begin
        READY = 1'b0;
      end
    endcase
  end

  // Operand capture, iteration and result write-back
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mcand_r  <= {N{1'b0}};
      mplier_r <= {N{1'b0}};
      acc_r    <= {(2*N){1'b0}};
      neg_r    <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      hi_r     <= {N{1'b0}};
      lo_r     <= {N{1'b0}};
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
            mcand_r  <= mag_n(A, SIGNED);
            mplier_r <= mag_n(B, SIGNED);
            neg_r    <= SIGNED & (A[N-1] ^ B[N-1]);
            acc_r    <= {(2*N){1'b0}};
            cnt_r    <= {CW{1'b0}};
          end
        end
        S_RUN: begin
          acc_r    <= acc_step_s;
          mplier_r <= {1'b0, mplier_r[N-1:1]};
          cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        S_FIX: begin
          if (neg_r) begin
            {hi_r, lo_r} <= neg_2n(acc_r);
          end else begin
            {hi_r, lo_r} <= acc_r;
          end
        end
        default: begin
          neg_r <= neg_r;
        end
      endcase
    end
  end

  assign HI = hi_r;
  assign LO = lo_r;

endmodule

// File: tb/tb_seq_mult_32.sv
// Scoreboard bench for seq_mult_32: directed operand pairs with hand-computed products,
// checked by a monitor on every DONE pulse, plus reset, ignored-START and back-to-back cases.
module tb_seq_mult_32;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic        SIGNED;
  logic [31:0] A;
  logic [31:0] B;
  logic        READY;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    logic [63:0] prod;
    int          start_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          done_cycs[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  logic [63:0] prev_prod = 64'd0;

  seq_mult_32 dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SIGNED(SIGNED),
    .A(A), .B(B), .READY(READY), .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Monitor: protocol invariants every cycle, scoreboard compare on DONE
  always @(negedge CLK) begin
    if (!RESET) begin
      chk("ready_busy_exclusive", {63'd0, READY ^ BUSY}, 64'd1);
      if (!DONE) begin
        chk("hilo_hold", {HI, LO}, prev_prod);
      end else begin
        done_cnt++;
        done_cycs.push_back(cyc);
        if (sb_q.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("product", {HI, LO}, e.prod);
          chk("latency", 64'(cyc - e.start_cyc), 64'd33);
        end
      end
    end
    prev_prod = {HI, LO};
  end

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] prod, input bit hold);
    exp_t e;
    bit   got_ready = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (READY) begin
        got_ready = 1'b1;
        break;
      end
    end
    chk("ready_timeout", {63'd0, got_ready}, 64'd1);
    SIGNED = s;
    A      = a;
    B      = b;
    START  = 1'b1;
    @(posedge CLK);
    #1;
    e.prod      = prod;
    e.start_cyc = cyc;
    sb_q.push_back(e);
    if (!hold) START = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (sb_q.size() == 0) break;
    end
    chk("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int base;
    RESET  = 1'b1;
    START  = 1'b0;
    SIGNED = 1'b0;
    A      = 32'd0;
    B      = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_ready", {63'd0, READY}, 64'd1);
    chk("reset_busy",  {63'd0, BUSY},  64'd0);
    chk("reset_done",  {63'd0, DONE},  64'd0);
    chk("reset_hilo",  {HI, LO},       64'd0);
    #2 RESET = 1'b0;

    // T1 - T3 and additional corners
    issue(1'b0, 32'd3,          32'd5,          64'h00000000_0000000F, 1'b0);
    issue(1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, 1'b0);
    issue(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001, 1'b0);
    issue(1'b1, 32'hFFFFFFF9,   32'd6,          64'hFFFFFFFF_FFFFFFD6, 1'b0);
    issue(1'b1, 32'h80000000,   32'h80000000,   64'h40000000_00000000, 1'b0);
    issue(1'b0, 32'h80000000,   32'h80000000,   64'h40000000_00000000, 1'b0);
    issue(1'b1, 32'h80000000,   32'd1,          64'hFFFFFFFF_80000000, 1'b0);
    issue(1'b1, 32'h7FFFFFFF,   32'h7FFFFFFF,   64'h3FFFFFFF_00000001, 1'b0);
    issue(1'b1, 32'd5,          32'hFFFFFFFD,   64'hFFFFFFFF_FFFFFFF1, 1'b0);
    issue(1'b0, 32'hFFFFFFFF,   32'd2,          64'h00000001_FFFFFFFE, 1'b0);
    drain();

    // T4: START pulses during RUN with other operands are ignored
    d0 = done_cnt;
    issue(1'b0, 32'h12345678, 32'h00000010, 64'h00000001_23456780, 1'b0);
    repeat (4) @(posedge CLK);
    #1;
    START = 1'b1; SIGNED = 1'b1; A = 32'hDEADBEEF; B = 32'h0000ABCD;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (14) @(posedge CLK);
    #1;
    START = 1'b1; SIGNED = 1'b0; A = 32'h00000007; B = 32'h00000009;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    chk("ignored_start_one_done", 64'(done_cnt - d0), 64'd1);
    drain();

    // T5: asynchronous reset mid-RUN discards the operation
    issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0);
    repeat (10) @(posedge CLK);
    #3 RESET = 1'b1;
    #1;
    chk("midrun_reset_ready", {63'd0, READY}, 64'd1);
    chk("midrun_reset_busy",  {63'd0, BUSY},  64'd0);
    chk("midrun_reset_done",  {63'd0, DONE},  64'd0);
    chk("midrun_reset_hilo",  {HI, LO},       64'd0);
    sb_q.delete();
    d0 = done_cnt;
    repeat (2) @(posedge CLK);
    #3 RESET = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    chk("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
    issue(1'b0, 32'd3, 32'd5, 64'h00000000_0000000F, 1'b0);
    drain();

    // T6: back-to-back with START held high
    base = done_cycs.size();
    issue(1'b0, 32'd2,        32'd3,          64'h00000000_00000006, 1'b1);
    issue(1'b0, 32'd0,        32'hFFFFFFFF,   64'h00000000_00000000, 1'b1);
    issue(1'b1, 32'hFFFFFFFF, 32'd1,          64'hFFFFFFFF_FFFFFFFF, 1'b0);
    drain();
    if (done_cycs.size() >= base + 3) begin
      chk("b2b_gap1", 64'(done_cycs[base+1] - done_cycs[base]),   64'd34);
      chk("b2b_gap2", 64'(done_cycs[base+2] - done_cycs[base+1]), 64'd34);
    end else begin
      chk("b2b_done_count", 64'(done_cycs.size() - base), 64'd3);
    end

    repeat (5) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
